// File: rtl/spi_master_adapter_if.sv
// Host request/response streams and SPI master push/pull frame signals
// between the SPI master adapter and its surroundings.
interface spi_master_adapter_if #(
  parameter int nbits = 8
);
  // host write stream
  logic [nbits-3:0] recv_msg;
  logic             recv_val;
  logic             recv_rdy;
  // host read stream
  logic [nbits-3:0] send_msg;
  logic             send_val;
  logic             send_rdy;
  // SPI master frame push
  logic [nbits-1:0] spi_send_msg;
  logic             spi_send_val;
  logic             spi_send_rdy;
  // SPI master frame return
  logic [nbits-1:0] spi_recv_msg;
  logic             spi_recv_val;

  // adapter side
  modport master (
    input  recv_msg, recv_val, send_rdy, spi_send_rdy, spi_recv_msg, spi_recv_val,
    output recv_rdy, send_msg, send_val, spi_send_msg, spi_send_val
  );

  // host / SPI master side
  modport slave (
    output recv_msg, recv_val, send_rdy, spi_send_rdy, spi_recv_msg, spi_recv_val,
    input  recv_rdy, send_msg, send_val, spi_send_msg, spi_send_val
  );
endinterface

// File: rtl/spi_master_adapter.sv
// Host-side SPI adapter: packs host writes into frames, polls the minion
// for read data, tracks minion write space and buffers returned data.
//
// state | meaning
// IDLE  | no transaction outstanding; a frame is offered to the SPI master
// BUSY  | one transaction in flight; waiting for the returned frame
module spi_master_adapter #(
  parameter int nbits       = 8,
  parameter int num_entries = 2
) (
  input logic                  clk,
  input logic                  reset,
  spi_master_adapter_if.master bus
);

  localparam int cw = $clog2(num_entries) + 1;
  localparam int pw = (num_entries > 1) ? $clog2(num_entries) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_next;
  logic             minion_spc;
  logic             rd_pending;
  logic             rd_room;
  logic             val_wrt;
  logic             val_rd;
  logic             launch;
  logic             complete;
  logic             push;
  logic             push_ok;
  logic             pop;
  logic             fifo_val;
  logic             spi_send_val_c;
  logic             recv_rdy_c;
  logic [nbits-1:0] spi_send_msg_c;
  logic [cw-1:0]    count;
  logic [pw-1:0]    rd_ptr;
  logic [pw-1:0]    wr_ptr;
  logic [nbits-3:0] mem [num_entries];

  function automatic logic [pw-1:0] ptr_next(input logic [pw-1:0] p);
    return (p == pw'(num_entries - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rd_room  = (count < cw'(num_entries));
  assign fifo_val = (count != '0);
  assign pop      = fifo_val & bus.send_rdy;
  assign push     = complete & rd_pending & bus.spi_recv_msg[nbits-1];
  // a returned frame only lands when the slot is free or being vacated
  assign push_ok  = push & (rd_room | pop);

  // next state and frame/handshake outputs; nothing is offered under reset or while busy
  always_comb begin
    state_next     = state;
    val_wrt        = 1'b0;
    val_rd         = 1'b0;
    spi_send_val_c = 1'b0;
    spi_send_msg_c = '0;
    recv_rdy_c     = 1'b0;
    launch         = 1'b0;
    complete       = 1'b0;
    case (state)
      IDLE: begin
        if (!reset) begin
          val_wrt        = bus.recv_val & minion_spc;
          val_rd         = rd_room;
          spi_send_val_c = bus.recv_val | rd_room;
          spi_send_msg_c = {val_wrt, val_rd, (val_wrt ? bus.recv_msg : '0)};
          recv_rdy_c     = bus.spi_send_rdy & minion_spc;
          launch         = spi_send_val_c & bus.spi_send_rdy;
          if (launch) state_next = BUSY;
        end
      end
      BUSY: begin
        if (bus.spi_recv_val) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state, pending-read flag and minion write-space flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rd_pending <= 1'b0;
      minion_spc <= 1'b1;
    end else begin
      state <= state_next;
      if (launch)   rd_pending <= val_rd;
      if (complete) minion_spc <= bus.spi_recv_msg[nbits-2];
    end
  end

  // response FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_next(wr_ptr);
      if (pop)     rd_ptr <= ptr_next(rd_ptr);
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // response FIFO storage; stale contents are harmless since pointers reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.spi_recv_msg[nbits-3:0];
  end

  assign bus.send_val     = fifo_val;
  assign bus.send_msg     = fifo_val ? mem[rd_ptr] : '0;
  assign bus.spi_send_val = spi_send_val_c;
  assign bus.spi_send_msg = spi_send_msg_c;
  assign bus.recv_rdy     = recv_rdy_c;

endmodule

// File: tb/tb_spi_master_adapter.sv
// Directed bench for spi_master_adapter (nbits=8, num_entries=2) with a
// scoreboard queue of expected host read data.
module tb_spi_master_adapter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [5:0] sb[$];

  spi_master_adapter_if #(.nbits(8)) bus ();

  spi_master_adapter #(.nbits(8), .num_entries(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // offer one frame to the adapter and take it as a launch
  task automatic launch(input string tag, input logic [7:0] exp_frame, input logic exp_rdy);
    bus.spi_send_rdy = 1'b1;
    #1;
    chk({tag, "_spi_send_val"}, 8'(bus.spi_send_val), 8'h01);
    chk({tag, "_spi_send_msg"}, bus.spi_send_msg, exp_frame);
    chk({tag, "_recv_rdy"}, 8'(bus.recv_rdy), 8'(exp_rdy));
    @(posedge clk); #1;
    bus.spi_send_rdy = 1'b0;
    #1;
    chk({tag, "_busy_send_val"}, 8'(bus.spi_send_val), 8'h00);
  endtask

  // return a frame; when a read was asked for and val=1 the data is expected at the host
  task automatic complete(input logic [7:0] frame, input logic exp_push);
    bus.spi_recv_val = 1'b1;
    bus.spi_recv_msg = frame;
    if (exp_push) sb.push_back(frame[5:0]);
    @(posedge clk); #1;
    bus.spi_recv_val = 1'b0;
    bus.spi_recv_msg = '0;
  endtask

  // host takes the FIFO head and compares it with the scoreboard
  task automatic pop(input string tag);
    bus.send_rdy = 1'b1;
    #1;
    chk({tag, "_send_val"}, 8'(bus.send_val), 8'h01);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed data 0x%0h expected no data", tag, bus.send_msg);
    end else begin
      chk({tag, "_send_msg"}, 8'(bus.send_msg), 8'(sb.pop_front()));
    end
    @(posedge clk); #1;
    bus.send_rdy = 1'b0;
  endtask

  // minion write space seen through recv_rdy without advancing time past an edge
  task automatic spc_chk(input string tag, input logic exp);
    bus.spi_send_rdy = 1'b1;
    #1;
    chk(tag, 8'(bus.recv_rdy), 8'(exp));
    bus.spi_send_rdy = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.recv_msg     = 6'h2A;
    bus.recv_val     = 1'b1;
    bus.send_rdy     = 1'b0;
    bus.spi_send_rdy = 1'b1;
    bus.spi_recv_msg = '0;
    bus.spi_recv_val = 1'b0;

    // reset values with the host and master both asking
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_recv_rdy", 8'(bus.recv_rdy), 8'h00);
    chk("rst_spi_send_val", 8'(bus.spi_send_val), 8'h00);
    chk("rst_spi_send_msg", bus.spi_send_msg, 8'h00);
    chk("rst_send_val", 8'(bus.send_val), 8'h00);
    chk("rst_send_msg", 8'(bus.send_msg), 8'h00);
    bus.spi_send_rdy = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // single write: val_wrt=1, val_rd=1, payload 0x2A
    launch("wr1", 8'hEA, 1'b1);
    bus.recv_val = 1'b0;
    complete(8'b0100_0000, 1'b0);
    #1;
    chk("wr1_send_val", 8'(bus.send_val), 8'h00);
    spc_chk("wr1_spc", 1'b1);

    // read return from a poll
    launch("poll1", 8'h40, 1'b1);
    complete(8'b1101_0101, 1'b1);
    pop("rd1");

    // minion full: poll carries no write, then space returns and write goes out
    launch("poll2", 8'h40, 1'b1);
    complete(8'b0000_0000, 1'b0);
    spc_chk("full_spc", 1'b0);
    bus.recv_val = 1'b1;
    bus.recv_msg = 6'h33;
    launch("poll_nowr", 8'h40, 1'b0);
    complete(8'b0100_0000, 1'b0);
    launch("wr2", 8'hF3, 1'b1);
    bus.recv_val = 1'b0;
    complete(8'b0100_0000, 1'b0);

    // fill the FIFO with the host stalled
    launch("f1", 8'h40, 1'b1);
    complete(8'hC1, 1'b1);
    launch("f2", 8'h40, 1'b1);
    complete(8'hC2, 1'b1);
    bus.spi_send_rdy = 1'b1;
    #1;
    chk("full_spi_send_val", 8'(bus.spi_send_val), 8'h00);
    chk("full_send_val", 8'(bus.send_val), 8'h01);
    chk("full_head", 8'(bus.send_msg), 8'(sb[0]));
    bus.spi_send_rdy = 1'b0;
    // write-only launch while full; a stray val=1 reply must be dropped
    bus.recv_val = 1'b1;
    bus.recv_msg = 6'h05;
    launch("f3", 8'h85, 1'b1);
    bus.recv_val = 1'b0;
    complete(8'hC7, 1'b0);
    pop("d1");
    // push and pop in the same cycle keep the occupancy
    launch("f4", 8'h40, 1'b1);
    bus.send_rdy = 1'b1;
    #1;
    chk("pp_head", 8'(bus.send_msg), 8'(sb.pop_front()));
    complete(8'hC9, 1'b1);
    bus.send_rdy = 1'b0;
    pop("d3");
    #1;
    chk("drained_send_val", 8'(bus.send_val), 8'h00);
    chk("drained_send_msg", 8'(bus.send_msg), 8'h00);

    // pointer wrap-around over several returns
    for (int i = 0; i < 5; i++) begin
      launch("wrap", 8'h40, 1'b1);
      complete(8'hC0 | 8'(8'h10 + i), 1'b1);
      pop("wrap");
    end

    // reset while busy, then a late returned frame that must be ignored
    launch("rb", 8'h40, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.spi_recv_val = 1'b1;
    bus.spi_recv_msg = 8'h85;
    @(posedge clk); #1;
    bus.spi_recv_val = 1'b0;
    bus.spi_recv_msg = '0;
    #1;
    chk("rb_send_val", 8'(bus.send_val), 8'h00);
    chk("rb_idle_offer", 8'(bus.spi_send_val), 8'h01);
    spc_chk("rb_spc", 1'b1);

    chk("sb_empty", 8'(sb.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
